// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared constants for the multi-cycle MIPS32 main control FSM:
// state encodings, opcode/funct values, mux select and ALU operation codes.
package mips_ctrl_pkg;

    localparam int OPW = 6;
    localparam int FNW = 6;
    localparam int STW = 4;

    localparam logic [3:0] S_RESET    = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_EXEC_R   = 4'd3;
    localparam logic [3:0] S_WB_R     = 4'd4;
    localparam logic [3:0] S_EXEC_I   = 4'd5;
    localparam logic [3:0] S_EXEC_IZ  = 4'd6;
    localparam logic [3:0] S_WB_I     = 4'd7;
    localparam logic [3:0] S_MEM_ADDR = 4'd8;
    localparam logic [3:0] S_MEM_RD   = 4'd9;
    localparam logic [3:0] S_WB_MEM   = 4'd10;
    localparam logic [3:0] S_MEM_WR   = 4'd11;
    localparam logic [3:0] S_BRANCH   = 4'd12;
    localparam logic [3:0] S_JUMP     = 4'd13;
    localparam logic [3:0] S_TRAP     = 4'd14;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;

    localparam logic [2:0] ALUB_RS       = 3'b000;
    localparam logic [2:0] ALUB_SHAMT    = 3'b001;
    localparam logic [2:0] ALUB_SEXT     = 3'b010;
    localparam logic [2:0] ALUB_SEXT_SL2 = 3'b011;
    localparam logic [2:0] ALUB_FOUR     = 3'b100;
    localparam logic [2:0] ALUB_ZEXT     = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [2:0] {
        CL_RTYPE,
        CL_MEM,
        CL_BRANCH,
        CL_JUMP,
        CL_IMM_S,
        CL_IMM_Z,
        CL_ILLEGAL
    } instr_class_t;

endpackage

// File: rtl/multicycle_ctrl_fsm_decoder.sv
// Combinational main decoder: classifies the instruction held in IR so the
// control FSM only has to branch on a small class code.
module mips_main_decoder
    import mips_ctrl_pkg::*;
#(
    parameter int OPW = 6,
    parameter int FNW = 6
) (
    input  logic [OPW-1:0] opcode,
    input  logic [FNW-1:0] funct,
    output instr_class_t   iclass,
    output logic           is_store,
    output logic           is_shift
);

    // Opcode to instruction class; anything unlisted traps.
    always_comb begin
        iclass = CL_ILLEGAL;
        case (opcode)
            OP_RTYPE:        iclass = CL_RTYPE;
            OP_LW, OP_SW:    iclass = CL_MEM;
            OP_BEQ, OP_BNE:  iclass = CL_BRANCH;
            OP_J:            iclass = CL_JUMP;
            OP_ADDI, OP_SLTI: iclass = CL_IMM_S;
            OP_ANDI, OP_ORI: iclass = CL_IMM_Z;
            default:         iclass = CL_ILLEGAL;
        endcase
    end

    // Shift-by-immediate R-types take their B operand from shamt.
    always_comb begin
        is_store = (opcode == OP_SW);
        is_shift = (funct == FN_SLL) || (funct == FN_SRL);
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multi-cycle MIPS32 core.
//
// state      | meaning
// S_RESET    | held in reset, all outputs low
// S_FETCH    | read instruction at PC, load IR and PC+4 on mem_ready
// S_DECODE   | compute branch target into ALUOut, dispatch on opcode
// S_EXEC_R   | R-type ALU operation
// S_WB_R     | write ALUOut to rd
// S_EXEC_I   | immediate op, sign-extended operand
// S_EXEC_IZ  | immediate op, zero-extended operand
// S_WB_I     | write ALUOut to rt
// S_MEM_ADDR | effective address for lw/sw
// S_MEM_RD   | data read, wait for mem_ready
// S_WB_MEM   | write MDR to rt
// S_MEM_WR   | data write, wait for mem_ready
// S_BRANCH   | compare and conditional PC load
// S_JUMP     | PC load from jump target
// S_TRAP     | illegal opcode, stuck until reset
module multicycle_ctrl_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int OPW = 6,
    parameter int FNW = 6,
    parameter int STW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [OPW-1:0] opcode,
    input  logic [FNW-1:0] funct,
    input  logic           zero,
    input  logic           mem_ready,
    output logic           pc_write,
    output logic           pc_write_cond,
    output logic [1:0]     pc_src,
    output logic           iord,
    output logic           mem_read,
    output logic           mem_write,
    output logic           ir_write,
    output logic           mem_to_reg,
    output logic           reg_dst,
    output logic           reg_write,
    output logic           alu_src_a,
    output logic [2:0]     alu_src_b,
    output logic [1:0]     alu_op,
    output logic           illegal_op
);

    logic [STW-1:0] state;
    logic [STW-1:0] state_next;
    instr_class_t   iclass;
    logic           is_store;
    logic           is_shift;

    // The branch decision (zero ^ bne) is resolved in the datapath PC enable.
    logic unused_zero;
    assign unused_zero = zero;

    mips_main_decoder #(
        .OPW(OPW),
        .FNW(FNW)
    ) u_decoder (
        .opcode  (opcode),
        .funct   (funct),
        .iclass  (iclass),
        .is_store(is_store),
        .is_shift(is_shift)
    );

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_RESET;
        else        state <= state_next;
    end

    // Next-state logic, memory states hold until mem_ready.
    always_comb begin
        state_next = state;
        case (state)
            S_RESET:    state_next = S_FETCH;
            S_FETCH:    if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                case (iclass)
                    CL_RTYPE:  state_next = S_EXEC_R;
                    CL_MEM:    state_next = S_MEM_ADDR;
                    CL_BRANCH: state_next = S_BRANCH;
                    CL_JUMP:   state_next = S_JUMP;
                    CL_IMM_S:  state_next = S_EXEC_I;
                    CL_IMM_Z:  state_next = S_EXEC_IZ;
                    default:   state_next = S_TRAP;
                endcase
            end
            S_EXEC_R:   state_next = S_WB_R;
            S_WB_R:     state_next = S_FETCH;
            S_EXEC_I,
            S_EXEC_IZ:  state_next = S_WB_I;
            S_WB_I:     state_next = S_FETCH;
            S_MEM_ADDR: state_next = is_store ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (mem_ready) state_next = S_WB_MEM;
            S_WB_MEM:   state_next = S_FETCH;
            S_MEM_WR:   if (mem_ready) state_next = S_FETCH;
            S_BRANCH:   state_next = S_FETCH;
            S_JUMP:     state_next = S_FETCH;
            S_TRAP:     state_next = S_TRAP;
            default:    state_next = S_RESET;
        endcase
    end

    // Output decode; FETCH commits IR/PC only in the cycle the read completes.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = PCSRC_ALU;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = ALUB_RS;
        alu_op        = ALUOP_ADD;
        illegal_op    = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = ALUB_FOUR;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    pc_src   = PCSRC_ALU;
                end
            end
            S_DECODE:   alu_src_b = ALUB_SEXT_SL2;
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
                alu_src_b = is_shift ? ALUB_SHAMT : ALUB_RS;
            end
            S_WB_R: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_SEXT;
                alu_op    = ALUOP_IMM;
            end
            S_EXEC_IZ: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_ZEXT;
                alu_op    = ALUOP_IMM;
            end
            S_WB_I:     reg_write = 1'b1;
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_SEXT;
            end
            S_MEM_RD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
            end
            S_WB_MEM: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_MEM_WR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_src        = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = PCSRC_JUMP;
            end
            S_TRAP:     illegal_op = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for the multi-cycle control FSM. Inputs change 1 ns after the
// rising edge, outputs are compared on the falling edge as one packed vector:
// {pc_write, pc_write_cond, pc_src, iord, mem_read, mem_write, ir_write,
//  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, illegal_op}
module tb_multicycle_ctrl_fsm;

    localparam logic [17:0] V_ZERO     = 18'b0_0_00_0_0_0_0_0_0_0_0_000_00_0;
    localparam logic [17:0] V_FETCH_GO = 18'b1_0_00_0_1_0_1_0_0_0_0_100_00_0;
    localparam logic [17:0] V_FETCH_WT = 18'b0_0_00_0_1_0_0_0_0_0_0_100_00_0;
    localparam logic [17:0] V_DECODE   = 18'b0_0_00_0_0_0_0_0_0_0_0_011_00_0;
    localparam logic [17:0] V_EXEC_RS  = 18'b0_0_00_0_0_0_0_0_0_0_1_000_10_0;
    localparam logic [17:0] V_EXEC_SH  = 18'b0_0_00_0_0_0_0_0_0_0_1_001_10_0;
    localparam logic [17:0] V_WB_R     = 18'b0_0_00_0_0_0_0_0_1_1_0_000_00_0;
    localparam logic [17:0] V_EXEC_I   = 18'b0_0_00_0_0_0_0_0_0_0_1_010_11_0;
    localparam logic [17:0] V_EXEC_IZ  = 18'b0_0_00_0_0_0_0_0_0_0_1_101_11_0;
    localparam logic [17:0] V_WB_I     = 18'b0_0_00_0_0_0_0_0_0_1_0_000_00_0;
    localparam logic [17:0] V_MADDR    = 18'b0_0_00_0_0_0_0_0_0_0_1_010_00_0;
    localparam logic [17:0] V_MEM_RD   = 18'b0_0_00_1_1_0_0_0_0_0_0_000_00_0;
    localparam logic [17:0] V_WB_MEM   = 18'b0_0_00_0_0_0_0_1_0_1_0_000_00_0;
    localparam logic [17:0] V_MEM_WR   = 18'b0_0_00_1_0_1_0_0_0_0_0_000_00_0;
    localparam logic [17:0] V_BRANCH   = 18'b0_1_01_0_0_0_0_0_0_0_1_000_01_0;
    localparam logic [17:0] V_JUMP     = 18'b1_0_10_0_0_0_0_0_0_0_0_000_00_0;
    localparam logic [17:0] V_TRAP     = 18'b0_0_00_0_0_0_0_0_0_0_0_000_00_1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] pc_src, alu_op;
    logic [2:0] alu_src_b;
    logic [17:0] outs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign outs = {pc_write, pc_write_cond, pc_src, iord, mem_read, mem_write, ir_write,
                   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, illegal_op};

    multicycle_ctrl_fsm dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode       (opcode),
        .funct        (funct),
        .zero         (zero),
        .mem_ready    (mem_ready),
        .pc_write     (pc_write),
        .pc_write_cond(pc_write_cond),
        .pc_src       (pc_src),
        .iord         (iord),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .ir_write     (ir_write),
        .mem_to_reg   (mem_to_reg),
        .reg_dst      (reg_dst),
        .reg_write    (reg_write),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .illegal_op   (illegal_op)
    );

    // Power-on reset, then one S_RESET cycle, then FETCH (left waiting).
    task automatic test_reset();
        rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'd0; funct = 6'd0; zero = 1'b0;
        @(negedge clk);
        checks++;
        if (outs !== V_ZERO) begin
            errors++; $display("FAIL reset_hold: got %b expected %b", outs, V_ZERO);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (outs !== V_ZERO) begin
            errors++; $display("FAIL reset_state: got %b expected %b", outs, V_ZERO);
        end
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (outs !== V_FETCH_WT) begin
            errors++; $display("FAIL reset_to_fetch: got %b expected %b", outs, V_FETCH_WT);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        logic [17:0] exp [5] = '{V_FETCH_GO, V_DECODE, V_EXEC_RS, V_WB_R, V_FETCH_WT};
        logic        rdy [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        opcode = 6'b000000; funct = 6'b100000;
        for (int i = 0; i < 5; i++) begin
            mem_ready = rdy[i];
            @(negedge clk);
            checks++;
            if (outs !== exp[i]) begin
                errors++; $display("FAIL add cycle %0d: got %b expected %b", i + 1, outs, exp[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sll();
        logic [17:0] exp [5] = '{V_FETCH_GO, V_DECODE, V_EXEC_SH, V_WB_R, V_FETCH_WT};
        logic        rdy [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        opcode = 6'b000000; funct = 6'b000000;
        for (int i = 0; i < 5; i++) begin
            mem_ready = rdy[i];
            @(negedge clk);
            checks++;
            if (outs !== exp[i]) begin
                errors++; $display("FAIL sll cycle %0d: got %b expected %b", i + 1, outs, exp[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_imm();
        logic [17:0] exp_ori  [5] = '{V_FETCH_GO, V_DECODE, V_EXEC_IZ, V_WB_I, V_FETCH_WT};
        logic [17:0] exp_addi [5] = '{V_FETCH_GO, V_DECODE, V_EXEC_I, V_WB_I, V_FETCH_WT};
        logic        rdy [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        opcode = 6'b001101; funct = 6'b000010;
        for (int i = 0; i < 5; i++) begin
            mem_ready = rdy[i];
            @(negedge clk);
            checks++;
            if (outs !== exp_ori[i]) begin
                errors++; $display("FAIL ori cycle %0d: got %b expected %b", i + 1, outs, exp_ori[i]);
            end
            @(posedge clk); #1;
        end
        opcode = 6'b001000; funct = 6'b100000;
        for (int i = 0; i < 5; i++) begin
            mem_ready = rdy[i];
            @(negedge clk);
            checks++;
            if (outs !== exp_addi[i]) begin
                errors++; $display("FAIL addi cycle %0d: got %b expected %b", i + 1, outs, exp_addi[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    // lw with 2 wait cycles in FETCH and 3 in MEM_RD: 5 + 5 = 10 cycles.
    task automatic test_lw_stall();
        logic [17:0] exp [11] = '{V_FETCH_WT, V_FETCH_WT, V_FETCH_GO, V_DECODE, V_MADDR,
                                  V_MEM_RD, V_MEM_RD, V_MEM_RD, V_MEM_RD, V_WB_MEM, V_FETCH_WT};
        logic        rdy [11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        int ir_cnt = 0;
        int rw_cnt = 0;
        opcode = 6'b100011; funct = 6'b000000;
        for (int i = 0; i < 11; i++) begin
            mem_ready = rdy[i];
            @(negedge clk);
            if (i < 10) begin
                ir_cnt += int'(ir_write);
                rw_cnt += int'(reg_write);
            end
            checks++;
            if (outs !== exp[i]) begin
                errors++; $display("FAIL lw cycle %0d: got %b expected %b", i + 1, outs, exp[i]);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (ir_cnt != 1) begin
            errors++; $display("FAIL lw ir_write pulses: got %0d expected 1", ir_cnt);
        end
        checks++;
        if (rw_cnt != 1) begin
            errors++; $display("FAIL lw reg_write pulses: got %0d expected 1", rw_cnt);
        end
    endtask

    task automatic test_branch_jump();
        logic [17:0] exp_b [4] = '{V_FETCH_GO, V_DECODE, V_BRANCH, V_FETCH_WT};
        logic [17:0] exp_j [4] = '{V_FETCH_GO, V_DECODE, V_JUMP, V_FETCH_WT};
        logic        rdy [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        opcode = 6'b000100; zero = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mem_ready = rdy[i];
            @(negedge clk);
            checks++;
            if (outs !== exp_b[i]) begin
                errors++; $display("FAIL beq cycle %0d: got %b expected %b", i + 1, outs, exp_b[i]);
            end
            @(posedge clk); #1;
        end
        opcode = 6'b000101; zero = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_ready = rdy[i];
            @(negedge clk);
            checks++;
            if (outs !== exp_b[i]) begin
                errors++; $display("FAIL bne cycle %0d: got %b expected %b", i + 1, outs, exp_b[i]);
            end
            @(posedge clk); #1;
        end
        opcode = 6'b000010;
        for (int i = 0; i < 4; i++) begin
            mem_ready = rdy[i];
            @(negedge clk);
            checks++;
            if (outs !== exp_j[i]) begin
                errors++; $display("FAIL j cycle %0d: got %b expected %b", i + 1, outs, exp_j[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    // sw stalled in MEM_WR, reset asserted mid-cycle must clear outputs at once.
    task automatic test_reset_abort();
        logic [17:0] exp [4] = '{V_FETCH_GO, V_DECODE, V_MADDR, V_MEM_WR};
        logic        rdy [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        opcode = 6'b101011;
        for (int i = 0; i < 4; i++) begin
            mem_ready = rdy[i];
            @(negedge clk);
            checks++;
            if (outs !== exp[i]) begin
                errors++; $display("FAIL sw cycle %0d: got %b expected %b", i + 1, outs, exp[i]);
            end
            if (i < 3) begin
                @(posedge clk); #1;
            end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (outs !== V_ZERO) begin
            errors++; $display("FAIL abort_async: got %b expected %b", outs, V_ZERO);
        end
        mem_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (outs !== V_ZERO) begin
            errors++; $display("FAIL abort_hold: got %b expected %b", outs, V_ZERO);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (outs !== V_ZERO) begin
            errors++; $display("FAIL abort_reset_state: got %b expected %b", outs, V_ZERO);
        end
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (outs !== V_FETCH_WT) begin
            errors++; $display("FAIL abort_to_fetch: got %b expected %b", outs, V_FETCH_WT);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_trap();
        logic [17:0] exp [6] = '{V_FETCH_GO, V_DECODE, V_TRAP, V_TRAP, V_TRAP, V_TRAP};
        logic        rdy [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        opcode = 6'b111111;
        for (int i = 0; i < 6; i++) begin
            mem_ready = rdy[i];
            if (i == 4) opcode = 6'b000000;
            @(negedge clk);
            checks++;
            if (outs !== exp[i]) begin
                errors++; $display("FAIL trap cycle %0d: got %b expected %b", i + 1, outs, exp[i]);
            end
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs !== V_ZERO) begin
            errors++; $display("FAIL trap_clear: got %b expected %b", outs, V_ZERO);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (outs !== V_FETCH_WT) begin
            errors++; $display("FAIL trap_refetch: got %b expected %b", outs, V_FETCH_WT);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sll();
        test_imm();
        test_lw_stall();
        test_branch_jump();
        test_reset_abort();
        test_trap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
